// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program counter for the fetch stage. It drives the instruction-memory
//   address and supports stall, absolute jump, conditional relative branch,
//   and call/return through an internal return-address stack. The stack has
//   sticky overflow and underflow flags.
//
//   Parameters
//     ADDR_W      address width; all PC arithmetic wraps modulo 2**ADDR_W
//     STACK_DEPTH number of return-stack entries (>= 1)
//     RESET_VEC   PC value loaded on reset
//
//   Ports
//     clk        in   rising-edge clock
//     Reset      in   asynchronous active-high reset
//     en         in   1: execute op this cycle, 0: stall (clr_err still acts)
//     op         in   000 INC, 001 JMP, 010 BRA, 011 CALL, 100 RET,
//                     101 HOLD, 11x INC
//     cond       in   branch condition for BRA
//     target     in   absolute destination for JMP/CALL
//     offset     in   two's-complement displacement for BRA
//     clr_err    in   synchronous clear of stack_ovf/stack_unf
//     addr       out  current PC (registered)
//     depth      out  entries currently held on the return stack
//     stack_ovf  out  sticky: CALL issued while the stack was full
//     stack_unf  out  sticky: RET issued while the stack was empty
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                ADDR_W      = 6,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                             clk,
  input  logic                             Reset,
  input  logic                             en,
  input  logic [2:0]                       op,
  input  logic                             cond,
  input  logic [ADDR_W-1:0]                target,
  input  logic [ADDR_W-1:0]                offset,
  input  logic                             clr_err,
  output logic [ADDR_W-1:0]                addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_ovf,
  output logic                             stack_unf
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JMP  = 3'b001,
    OP_BRA  = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100,
    OP_HOLD = 3'b101
  } op_e;

  // Modular PC addition: the carry out of the top bit is simply dropped,
  // which gives both the max+1 -> 0 wrap and two's-complement offsets.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    return a + b;
  endfunction

  // Return addresses are data only; they are never reset, and depth alone
  // decides which entries are valid.
  logic [ADDR_W-1:0]  ret_stack [2**PTR_W];

  logic [ADDR_W-1:0]  inc_addr;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DEPTH_W-1:0] depth_nxt;
  logic [PTR_W-1:0]   push_idx;
  logic [PTR_W-1:0]   pop_idx;
  logic               push;
  logic               ovf_evt;
  logic               unf_evt;
  logic               ovf_nxt;
  logic               unf_nxt;

  assign inc_addr = wrap_add(addr, ADDR_W'(1));
  // A push happens only when depth < STACK_DEPTH, so the truncation is lossless.
  assign push_idx = PTR_W'(depth);
  // This index is only used when depth > 0.
  assign pop_idx  = PTR_W'(depth - DEPTH_W'(1));

  always_comb begin
    addr_nxt  = addr;
    depth_nxt = depth;
    push      = 1'b0;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    if (en) begin
      case (op)
        OP_JMP:  addr_nxt = target;
        OP_BRA:  addr_nxt = cond ? wrap_add(addr, offset) : inc_addr;
        OP_CALL: begin
          // The jump is always taken; only the push is dropped when the stack is full.
          addr_nxt = target;
          if (depth == FULL) begin
            ovf_evt = 1'b1;
          end else begin
            push      = 1'b1;
            depth_nxt = depth + DEPTH_W'(1);
          end
        end
        OP_RET: begin
          if (depth == '0) begin
            addr_nxt = inc_addr;
            unf_evt  = 1'b1;
          end else begin
            addr_nxt  = ret_stack[pop_idx];
            depth_nxt = depth - DEPTH_W'(1);
          end
        end
        OP_HOLD: addr_nxt = addr;
        default: addr_nxt = inc_addr;
      endcase
    end
    // A new error event overrides a same-cycle clear.
    ovf_nxt = ovf_evt | (stack_ovf & ~clr_err);
    unf_nxt = unf_evt | (stack_unf & ~clr_err);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      addr      <= RESET_VEC;
      depth     <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      addr      <= addr_nxt;
      depth     <= depth_nxt;
      stack_ovf <= ovf_nxt;
      stack_unf <= unf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ret_stack[push_idx] <= inc_addr;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer with ADDR_W=6, STACK_DEPTH=4 and
//   RESET_VEC=0. Directed scenarios and a randomized run are both checked
//   against a behavioural model. The model keeps the PC as an integer and the
//   return stack as a queue.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int ADDR_W = 6;
  localparam int SD     = 4;
  localparam int MOD    = 1 << ADDR_W;

  localparam logic [2:0] INC  = 3'd0;
  localparam logic [2:0] JMP  = 3'd1;
  localparam logic [2:0] BRA  = 3'd2;
  localparam logic [2:0] CALL = 3'd3;
  localparam logic [2:0] RET  = 3'd4;
  localparam logic [2:0] HOLD = 3'd5;

  logic              clk = 1'b0;
  logic              Reset = 1'b1;
  logic              en = 1'b0;
  logic [2:0]        op = '0;
  logic              cond = 1'b0;
  logic [ADDR_W-1:0] target = '0;
  logic [ADDR_W-1:0] offset = '0;
  logic              clr_err = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        depth;
  logic              stack_ovf;
  logic              stack_unf;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_addr;
  int m_stack[$];
  bit m_ovf;
  bit m_unf;

  pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(SD), .RESET_VEC('0)) dut (
    .clk(clk), .Reset(Reset), .en(en), .op(op), .cond(cond),
    .target(target), .offset(offset), .clr_err(clr_err),
    .addr(addr), .depth(depth), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_addr = 0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit e, input int o, input bit c,
                            input int t, input int off, input bit clr);
    bit ovf_ev = 1'b0;
    bit unf_ev = 1'b0;
    if (e) begin
      case (o)
        1: m_addr = t;
        2: m_addr = c ? (m_addr + off) % MOD : (m_addr + 1) % MOD;
        3: begin
          if (m_stack.size() < SD) m_stack.push_back((m_addr + 1) % MOD);
          else ovf_ev = 1'b1;
          m_addr = t;
        end
        4: begin
          if (m_stack.size() > 0) m_addr = m_stack.pop_back();
          else begin
            m_addr = (m_addr + 1) % MOD;
            unf_ev = 1'b1;
          end
        end
        5: m_addr = m_addr;
        default: m_addr = (m_addr + 1) % MOD;
      endcase
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (ovf_ev) m_ovf = 1'b1;
    if (unf_ev) m_unf = 1'b1;
  endtask

  // Present one op, clock it in, advance the model, and return 1 ns after the edge.
  task automatic cycle(input logic e, input logic [2:0] o, input logic c,
                       input logic [ADDR_W-1:0] t, input logic [ADDR_W-1:0] off,
                       input logic clr);
    en = e; op = o; cond = c; target = t; offset = off; clr_err = clr;
    @(posedge clk);
    model_step(e, int'(o), c, int'(t), int'(off), clr);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    model_reset();
    #2;
    n_tests++;
    if (addr !== 6'd0 || depth !== 3'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%0d depth=%0d ovf=%b unf=%b, required 0 0 0 0",
               addr, depth, stack_ovf, stack_unf);
    end
    @(posedge clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_inc_wrap();
    for (int i = 0; i < 70; i++) begin
      cycle(1'b1, INC, 1'b0, '0, '0, 1'b0);
      n_tests++;
      if (addr !== 6'((i + 1) % MOD)) begin
        n_fail++;
        $display("FAIL inc_wrap[%0d]: addr=%0d, required %0d", i, addr, (i + 1) % MOD);
      end
      n_tests++;
      if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
        n_fail++;
        $display("FAIL inc_flags[%0d]: ovf=%b unf=%b, required 0 0", i, stack_ovf, stack_unf);
      end
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, JMP, 1'b0, 6'd10, '0, 1'b0);
    n_tests++;
    if (addr !== 6'd10) begin
      n_fail++;
      $display("FAIL stall_setup: addr=%0d, required 10", addr);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, JMP, 1'b0, 6'd40, '0, 1'b0);
      n_tests++;
      if (addr !== 6'd10) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: addr=%0d, required 10", i, addr);
      end
    end
    cycle(1'b1, JMP, 1'b0, 6'd40, '0, 1'b0);
    n_tests++;
    if (addr !== 6'd40) begin
      n_fail++;
      $display("FAIL stall_release_jmp: addr=%0d, required 40", addr);
    end
  endtask

  task automatic test_branch();
    cycle(1'b1, JMP, 1'b0, 6'd20, '0, 1'b0);
    cycle(1'b1, BRA, 1'b1, '0, 6'h3C, 1'b0);
    n_tests++;
    if (addr !== 6'd16) begin
      n_fail++;
      $display("FAIL bra_taken_neg: addr=%0d, required 16", addr);
    end
    cycle(1'b1, BRA, 1'b0, '0, 6'd5, 1'b0);
    n_tests++;
    if (addr !== 6'd17) begin
      n_fail++;
      $display("FAIL bra_not_taken: addr=%0d, required 17", addr);
    end
    cycle(1'b1, JMP, 1'b0, 6'd2, '0, 1'b0);
    cycle(1'b1, BRA, 1'b1, '0, 6'h3C, 1'b0);
    n_tests++;
    if (addr !== 6'd62) begin
      n_fail++;
      $display("FAIL bra_wrap_low: addr=%0d, required 62", addr);
    end
    cycle(1'b1, HOLD, 1'b0, '0, '0, 1'b0);
    n_tests++;
    if (addr !== 6'd62) begin
      n_fail++;
      $display("FAIL hold: addr=%0d, required 62", addr);
    end
  endtask

  task automatic test_call_ret();
    int exp_a[4] = '{30, 50, 31, 6};
    int exp_d[4] = '{1, 2, 1, 0};
    logic [2:0] ops[4] = '{CALL, CALL, RET, RET};
    logic [ADDR_W-1:0] tg[4] = '{6'd30, 6'd50, 6'd0, 6'd0};
    cycle(1'b1, JMP, 1'b0, 6'd5, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, ops[i], 1'b0, tg[i], '0, 1'b0);
      n_tests++;
      if (addr !== 6'(exp_a[i]) || depth !== 3'(exp_d[i])) begin
        n_fail++;
        $display("FAIL call_ret[%0d]: addr=%0d depth=%0d, required %0d %0d",
                 i, addr, depth, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_overflow_underflow();
    int rets[5] = '{31, 21, 11, 4, 5};
    cycle(1'b1, JMP, 1'b0, 6'd3, '0, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b1, CALL, 1'b0, 6'(10 * i), '0, 1'b0);
    n_tests++;
    if (addr !== 6'd50 || depth !== 3'd4 || stack_ovf !== 1'b1 || stack_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow: addr=%0d depth=%0d ovf=%b unf=%b, required 50 4 1 0",
               addr, depth, stack_ovf, stack_unf);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, RET, 1'b0, '0, '0, 1'b0);
      n_tests++;
      if (addr !== 6'(rets[i]) || depth !== 3'(i < 4 ? 3 - i : 0)) begin
        n_fail++;
        $display("FAIL ret_chain[%0d]: addr=%0d depth=%0d, required %0d %0d",
                 i, addr, depth, rets[i], i < 4 ? 3 - i : 0);
      end
    end
    n_tests++;
    if (stack_ovf !== 1'b1 || stack_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_flags: ovf=%b unf=%b, required 1 1", stack_ovf, stack_unf);
    end
    // The clear must work while the sequencer is stalled.
    cycle(1'b0, INC, 1'b0, '0, '0, 1'b1);
    n_tests++;
    if (stack_ovf !== 1'b0 || stack_unf !== 1'b0 || addr !== 6'd5) begin
      n_fail++;
      $display("FAIL clr_err: ovf=%b unf=%b addr=%0d, required 0 0 5", stack_ovf, stack_unf, addr);
    end
    cycle(1'b0, RET, 1'b0, '0, '0, 1'b0);
    n_tests++;
    if (stack_unf !== 1'b0 || addr !== 6'd5) begin
      n_fail++;
      $display("FAIL stalled_ret: unf=%b addr=%0d, required 0 5", stack_unf, addr);
    end
    cycle(1'b1, RET, 1'b0, '0, '0, 1'b1);
    n_tests++;
    if (stack_unf !== 1'b1 || addr !== 6'd6) begin
      n_fail++;
      $display("FAIL error_beats_clear: unf=%b addr=%0d, required 1 6", stack_unf, addr);
    end
    cycle(1'b1, HOLD, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic e;
      logic clr;
      e   = ($urandom_range(7, 0) != 0);
      clr = ($urandom_range(9, 0) == 0);
      cycle(e, 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
            6'($urandom_range(MOD - 1, 0)), 6'($urandom_range(MOD - 1, 0)), clr);
      n_tests++;
      if (addr !== 6'(m_addr) || depth !== 3'(m_stack.size()) ||
          stack_ovf !== m_ovf || stack_unf !== m_unf) begin
        n_fail++;
        $display("FAIL random[%0d]: addr=%0d depth=%0d ovf=%b unf=%b, required %0d %0d %b %b",
                 i, addr, depth, stack_ovf, stack_unf, m_addr, m_stack.size(), m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_async_reset();
    Reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    Reset = 1'b0;
    cycle(1'b1, CALL, 1'b0, 6'd12, '0, 1'b0);
    cycle(1'b1, CALL, 1'b0, 6'd25, '0, 1'b0);
    n_tests++;
    if (depth !== 3'd2 || addr !== 6'd25) begin
      n_fail++;
      $display("FAIL async_setup: depth=%0d addr=%0d, required 2 25", depth, addr);
    end
    en = 1'b1; op = CALL; target = 6'd40; clr_err = 1'b0;
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (addr !== 6'd0 || depth !== 3'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: addr=%0d depth=%0d ovf=%b unf=%b, required 0 0 0 0",
               addr, depth, stack_ovf, stack_unf);
    end
    @(posedge clk);
    #1;
    Reset = 1'b0;
    cycle(1'b1, RET, 1'b0, '0, '0, 1'b0);
    n_tests++;
    if (addr !== 6'd1 || depth !== 3'd0 || stack_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_after_reset: addr=%0d depth=%0d unf=%b, required 1 0 1",
               addr, depth, stack_unf);
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_stall();
    test_branch();
    test_call_ret();
    test_overflow_underflow();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
